// File: rtl/polylut_add_pkg.sv
// ---------------------------------------------------------------------------
// polylut_add_pkg
// Shared constants and types for the PolyLUT-Add jet-substructure classifier
// core and its feeder shim.
//   N_FEAT features of FEAT_W bits pack into the IN_W-bit core input.
//   N_CLASS scores of CLASS_W bits (two's complement) form the OUT_W result.
//   argmax_scores() returns the index of the largest score, lowest on ties.
// ---------------------------------------------------------------------------
package polylut_add_pkg;

   localparam int N_FEAT      = 16;
   localparam int FEAT_W      = 7;
   localparam int IN_W        = 112;
   localparam int N_CLASS     = 5;
   localparam int CLASS_W     = 5;
   localparam int OUT_W       = 25;
   localparam int CLASS_IDX_W = 3;

   typedef enum logic {
      ST_FILL   = 1'b0,
      ST_LAUNCH = 1'b1
   } feeder_state_e;

   // Strict greater-than keeps the earliest index when scores tie.
   function automatic logic [CLASS_IDX_W-1:0] argmax_scores(input logic [OUT_W-1:0] v);
      logic [CLASS_IDX_W-1:0] best;
      logic signed [CLASS_W-1:0] best_s;
      logic signed [CLASS_W-1:0] cur;
      best   = '0;
      best_s = $signed(v[CLASS_W-1:0]);
      for (int c = 1; c < N_CLASS; c++) begin
         cur = $signed(v[c*CLASS_W +: CLASS_W]);
         if (cur > best_s) begin
            best_s = cur;
            best   = CLASS_IDX_W'(c);
         end
      end
      return best;
   endfunction

endpackage

// File: rtl/polylut_result_fifo.sv
// ---------------------------------------------------------------------------
// polylut_result_fifo
// Synchronous first-word-fall-through FIFO for classifier results.
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   i_push     : write i_data (ignored when full unless a pop frees a slot)
//   i_data     : write data
//   i_pop      : consume head entry (ignored when empty)
//   o_data     : head entry, zero while empty
//   o_valid    : FIFO not empty
// ---------------------------------------------------------------------------
module polylut_result_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_pop   = i_pop & ~w_empty;
   // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
   assign w_push  = i_push & (~w_full | w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_next(r_wptr);
         if (w_pop)  r_rptr <= ptr_next(r_rptr);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: ;
         endcase
      end
   end

   // Storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_data;
   end

   assign o_valid = ~w_empty;
   assign o_data  = w_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/polylut_add_feeder.sv
// ---------------------------------------------------------------------------
// polylut_add_feeder
// Front/back-end shim for the pipelined PolyLUT-Add classifier core.
// Packs 16 seven-bit feature beats into the 112-bit core input, launches the
// vector, tracks it through PIPE_LAT core stages and captures the result
// into a FWFT FIFO. Launches are credit-gated so the FIFO cannot overflow.
//   clk, rst            : clock, asynchronous active-high reset
//   s_valid/s_ready     : feature stream handshake
//   s_data, s_last      : feature value, end-of-frame marker
//   core_in             : registered packed vector to the core
//   core_out            : core result, 5 classes x 5 bits
//   m_valid/m_ready     : result stream handshake
//   m_data, m_class     : result scores, argmax class index
//   err_framing         : sticky framing error, cleared only by reset
// Build option: define POLYLUT_FEEDER_ARGMAX_EN to compute m_class at push
// time; otherwise m_class is tied to 0.
// ---------------------------------------------------------------------------
module polylut_add_feeder
   import polylut_add_pkg::*;
#(
   parameter int PIPE_LAT  = 5,
   parameter int OUT_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [FEAT_W-1:0]      s_data,
   input  logic                   s_last,
   output logic [IN_W-1:0]        core_in,
   input  logic [OUT_W-1:0]       core_out,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [OUT_W-1:0]       m_data,
   output logic [CLASS_IDX_W-1:0] m_class,
   output logic                   err_framing
);

   localparam int         CRED_W   = $clog2(OUT_DEPTH + 1);
   localparam logic [3:0] LAST_IDX = 4'(N_FEAT - 1);

   feeder_state_e r_state;
   feeder_state_e w_state_nxt;

   logic [3:0]        r_idx;
   logic [IN_W-1:0]   r_buf;
   logic [IN_W-1:0]   r_core_in;
   logic              r_err;
   logic [PIPE_LAT:0] r_dly;
   logic [CRED_W-1:0] r_credits;

   logic w_accept;
   logic w_launch;
   logic w_pop;
   logic w_push;
   logic w_fifo_valid;

   assign s_ready  = (r_state == ST_FILL) & ~rst;
   assign w_accept = s_valid & s_ready;
   assign w_launch = (r_state == ST_LAUNCH) & (r_credits != '0);
   assign w_pop    = w_fifo_valid & m_ready;
   // The tap sits PIPE_LAT+1 edges after the launch edge, which is where the
   // core's output register holds the launched vector's result.
   assign w_push   = r_dly[PIPE_LAT];

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_FILL;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_FILL:   if (w_accept && (r_idx == LAST_IDX)) w_state_nxt = ST_LAUNCH;
         ST_LAUNCH: if (w_launch)                        w_state_nxt = ST_FILL;
         default:                                        w_state_nxt = ST_FILL;
      endcase
   end

   // ---------------- packing / framing ----------------
   // An early s_last drops the partial frame by rewinding the index; stale
   // buffer bits are overwritten before the next launch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
         r_buf <= '0;
         r_err <= 1'b0;
      end else begin
         if (w_accept) begin
            if (r_idx == LAST_IDX) begin
               r_buf[int'(r_idx)*FEAT_W +: FEAT_W] <= s_data;
               if (!s_last) r_err <= 1'b1;
            end else if (s_last) begin
               r_err <= 1'b1;
               r_idx <= '0;
            end else begin
               r_buf[int'(r_idx)*FEAT_W +: FEAT_W] <= s_data;
               r_idx <= r_idx + 4'd1;
            end
         end
         if (w_launch) r_idx <= '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           r_core_in <= '0;
      else if (w_launch) r_core_in <= r_buf;
   end

   // ---------------- credits ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_credits <= CRED_W'(OUT_DEPTH);
      end else begin
         case ({w_launch, w_pop})
            2'b10:   r_credits <= r_credits - CRED_W'(1);
            2'b01:   if (r_credits != CRED_W'(OUT_DEPTH)) r_credits <= r_credits + CRED_W'(1);
            default: ;
         endcase
      end
   end

   // ---------------- launch delay line ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_dly <= '0;
      end else begin
         r_dly[0] <= w_launch;
         for (int k = 1; k <= PIPE_LAT; k++) r_dly[k] <= r_dly[k-1];
      end
   end

   // ---------------- result FIFO ----------------
`ifdef POLYLUT_FEEDER_ARGMAX_EN
   localparam int FW = OUT_W + CLASS_IDX_W;
   logic [FW-1:0] w_fifo_din;
   logic [FW-1:0] w_fifo_dout;
   assign w_fifo_din = {argmax_scores(core_out), core_out};
   assign m_data     = w_fifo_dout[OUT_W-1:0];
   assign m_class    = w_fifo_dout[FW-1:OUT_W];
`else
   localparam int FW = OUT_W;
   logic [FW-1:0] w_fifo_din;
   logic [FW-1:0] w_fifo_dout;
   assign w_fifo_din = core_out;
   assign m_data     = w_fifo_dout;
   assign m_class    = '0;
`endif

   polylut_result_fifo #(
      .WIDTH (FW),
      .DEPTH (OUT_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_fifo_din),
      .i_pop   (m_ready),
      .o_data  (w_fifo_dout),
      .o_valid (w_fifo_valid)
   );

   assign m_valid     = w_fifo_valid;
   assign core_in     = r_core_in;
   assign err_framing = r_err;

endmodule

// File: tb/tb_polylut_add_feeder.sv
// ---------------------------------------------------------------------------
// tb_polylut_add_feeder
// Directed sequence with random feature vectors. A pipelined core model
// produces results; an expected-result queue is filled from the frames the
// bench sends and compared against the results popped from the DUT.
// ---------------------------------------------------------------------------
module tb_polylut_add_feeder;

   localparam int PIPE_LAT  = 5;
   localparam int OUT_DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [6:0]   s_data = '0;
   logic         s_last = 1'b0;
   logic [111:0] core_in;
   logic [24:0]  core_out;
   logic         m_valid;
   logic         m_ready = 1'b0;
   logic [24:0]  m_data;
   logic [2:0]   m_class;
   logic         err_framing;

   polylut_add_feeder #(.PIPE_LAT(PIPE_LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .s_last(s_last), .core_in(core_in), .core_out(core_out), .m_valid(m_valid),
      .m_ready(m_ready), .m_data(m_data), .m_class(m_class), .err_framing(err_framing)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int occ    = 0;
   logic overflow_seen = 1'b0;
   int t_first = 0;
   int t_last  = 0;
   logic [27:0] exp_q[$];
   logic [27:0] got_q[$];

   // ---------------- core model ----------------
   logic [111:0] cpipe [PIPE_LAT];
   logic         ovr_en  = 1'b0;
   logic [24:0]  ovr_val = '0;

   function automatic logic [24:0] fold(input logic [111:0] v);
      return v[24:0] ^ v[49:25] ^ v[74:50] ^ v[99:75] ^ {13'b0, v[111:100]};
   endfunction

   always @(posedge clk) begin
      cpipe[0] <= core_in;
      for (int k = 1; k < PIPE_LAT; k++) cpipe[k] <= cpipe[k-1];
   end
   assign core_out = ovr_en ? ovr_val : fold(cpipe[PIPE_LAT-1]);

   // ---------------- reference ----------------
   function automatic int ref_argmax(input logic [24:0] v);
      int best_i = 0;
      int best_s = -100;
      for (int c = 0; c < 5; c++) begin
         int raw = int'(v[5*c +: 5]);
         int s   = (raw >= 16) ? raw - 32 : raw;
         if (s > best_s) begin best_s = s; best_i = c; end
      end
      return best_i;
   endfunction

   function automatic logic [27:0] expect_of(input logic [111:0] v);
      logic [24:0] d;
      logic [2:0]  c;
      d = ovr_en ? ovr_val : fold(v);
`ifdef POLYLUT_FEEDER_ARGMAX_EN
      c = 3'(ref_argmax(d));
`else
      c = 3'd0;
`endif
      return {c, d};
   endfunction

   function automatic logic [111:0] rand_vec();
      logic [111:0] v;
      for (int i = 0; i < 16; i++) v[7*i +: 7] = 7'($urandom);
      return v;
   endfunction

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         occ <= 0;
      end else begin
         if (dut.w_push && occ >= OUT_DEPTH && !(m_valid && m_ready)) overflow_seen <= 1'b1;
         if (m_valid && m_ready) got_q.push_back({m_class, m_data});
         occ <= occ + int'(dut.w_push) - int'(m_valid && m_ready);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // Sends nb beats of v, s_last on beat last_at; called and returning at a negedge.
   task automatic send_frame(input logic [111:0] v, input int nb, input int last_at);
      for (int i = 0; i < nb; i++) begin
         int n = 0;
         s_valid = 1'b1;
         s_data  = v[7*i +: 7];
         s_last  = (i == last_at);
         while (!s_ready && n < 400) begin @(negedge clk); n++; end
         if (n >= 400) begin chk("s_ready_timeout", 1'b0, 1'b1); break; end
         @(posedge clk);
         @(negedge clk);
         if (i == 0) t_first = cyc;
         t_last = cyc;
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (nb == 16) exp_q.push_back(expect_of(v));
   endtask

   task automatic drain_check(input string tag);
      int n = 0;
      while (got_q.size() < exp_q.size() && n < 500) begin @(negedge clk); n++; end
      chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
      while (exp_q.size() > 0) begin
         logic [27:0] e;
         logic [27:0] g;
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : 28'hxxxxxxx;
         chk(tag, g, e);
      end
      repeat (3) @(negedge clk);
      chk({tag, "_no_extra"}, 128'(got_q.size()), 128'd0);
      got_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      repeat (2) @(negedge clk);
      got_q.delete();
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- sequence ----------------
   initial begin
      logic [111:0] v;
      logic [111:0] v_prev;
      logic         saw;

      repeat (2) @(negedge clk);
      chk("rst_s_ready", s_ready, 1'b0);
      chk("rst_core_in", core_in, 112'd0);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_data", m_data, 25'd0);
      chk("rst_m_class", m_class, 3'd0);
      chk("rst_err", err_framing, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      chk("fill_s_ready", s_ready, 1'b1);
      chk("rst_credits", dut.r_credits, 3'd4);

      // Single frame, features 1..16, core echoes a fixed score vector.
      ovr_en  = 1'b1;
      ovr_val = {5'd0, 5'd3, 5'd9, 5'd2, 5'd1};
      m_ready = 1'b1;
      for (int i = 0; i < 16; i++) v[7*i +: 7] = 7'(i + 1);
      send_frame(v, 16, 15);
      chk("launch_not_early", core_in, 112'd0);
      @(negedge clk);
      chk("core_in_pack", core_in, v);
      chk("core_in_lsb", core_in[6:0], 7'd1);
      chk("core_in_msb", core_in[111:105], 7'd16);
      repeat (5) @(negedge clk);
      chk("push_not_early", m_valid, 1'b0);
      @(negedge clk);
      chk("push_edge6", m_valid, 1'b1);
      chk("single_m_data", m_data, ovr_val);
      chk("single_m_class", m_class, exp_q[0][27:25]);
      drain_check("single");
      ovr_en = 1'b0;

      // Back-to-back frames: one vector per 17 cycles.
      for (int f = 0; f < 3; f++) begin
         int t0;
         t0 = t_first;
         send_frame(rand_vec(), 16, 15);
         if (f != 0) t_first = t0;
      end
      chk("throughput_cycles", 128'(t_last - t_first), 128'd49);
      drain_check("throughput");

      // Backpressure: 4 results fill the FIFO, frame 5 parks in LAUNCH.
      m_ready = 1'b0;
      for (int f = 0; f < 5; f++) send_frame(rand_vec(), 16, 15);
      repeat (15) @(negedge clk);
      chk("bp_occupancy", 128'(occ), 128'd4);
      chk("bp_m_valid", m_valid, 1'b1);
      chk("bp_s_ready", s_ready, 1'b0);
      chk("bp_credits", dut.r_credits, 3'd0);
      chk("bp_none_popped", 128'(got_q.size()), 128'd0);
      chk("bp_head", m_data, exp_q[0][24:0]);
      m_ready = 1'b1;
      send_frame(rand_vec(), 16, 15);
      drain_check("bp_order");
      chk("no_err_yet", err_framing, 1'b0);

      // Early s_last on beat 5.
      v = rand_vec();
      send_frame(v, 5, 4);
      chk("early_err", err_framing, 1'b1);
      v_prev = core_in;
      repeat (20) @(negedge clk);
      chk("early_no_launch", core_in, v_prev);
      chk("early_no_result", 128'(got_q.size()), 128'd0);
      v = rand_vec();
      send_frame(v, 16, 15);
      @(negedge clk);
      chk("early_repack", core_in, v);
      drain_check("early_next");

      // Missing s_last on the final beat.
      do_reset();
      chk("reset_err_clear", err_framing, 1'b0);
      send_frame(rand_vec(), 16, -1);
      chk("missing_err", err_framing, 1'b1);
      drain_check("missing_last");

      // Reset three cycles after a launch.
      send_frame(rand_vec(), 16, 15);
      exp_q.delete();
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_core_in", core_in, 112'd0);
      chk("midrst_s_ready", s_ready, 1'b0);
      rst = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (m_valid) saw = 1'b1;
      end
      chk("midrst_no_push", saw, 1'b0);
      chk("midrst_no_result", 128'(got_q.size()), 128'd0);
      chk("midrst_credits", dut.r_credits, 3'd4);
      chk("midrst_core_in_after", core_in, 112'd0);
      got_q.delete();

      // Argmax tie: class scores c0..c4 = 2, 7, 7, -1, 0.
      ovr_en  = 1'b1;
      ovr_val = {5'd0, 5'h1F, 5'd7, 5'd7, 5'd2};
      send_frame(rand_vec(), 16, 15);
`ifdef POLYLUT_FEEDER_ARGMAX_EN
      chk("tie_ref_class", 128'(exp_q[0][27:25]), 128'd1);
`else
      chk("tie_ref_class", 128'(exp_q[0][27:25]), 128'd0);
`endif
      drain_check("tie");
      ovr_en = 1'b0;

      chk("no_push_into_full", overflow_seen, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
